// File: rtl/ntt_lane_dma.sv
// Vector DMA sequencer: streams source beats from memory port B into the NTT lane
// and writes the NTT output beats back to a destination region via a small FIFO.
module ntt_lane_dma #(
   parameter int LANE       = 8,
   parameter int BEATS      = 64,
   parameter int ADDR_W     = 14,
   parameter int FIFO_DEPTH = 4
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   start,
   input  logic [ADDR_W-1:0]      src_addr,
   input  logic [ADDR_W-1:0]      dst_addr,
   output logic                   busy,
   output logic                   done,
   output logic                   err_overflow,
   output logic                   mem_renb,
   output logic                   mem_wenb,
   output logic [3:0]             mem_webb,
   output logic                   mem_w_is_vector,
   output logic [ADDR_W-1:0]      mem_addrb,
   output logic [LANE*32-1:0]     mem_datab,
   input  logic [LANE*32-1:0]     mem_qb,
   output logic                   ntt_valid_in,
   output logic [LANE*32-1:0]     ntt_lane_in,
   input  logic                   ntt_valid_out,
   input  logic [LANE*32-1:0]     ntt_lane_out
);

   localparam int W     = LANE * 32;
   localparam int CNT_W = $clog2(BEATS + 1);
   localparam int PTR_W = $clog2(FIFO_DEPTH);

   typedef enum logic {IDLE, RUN} state_t;

   state_t            state, state_nx;
   logic [ADDR_W-1:0] rd_ptr, wr_ptr;
   logic [CNT_W-1:0]  rd_cnt, wr_cnt;
   logic              done_q;
   logic              valid_in_q;
   logic              err_q;

   logic [W-1:0]      fifo_mem [FIFO_DEPTH];
   logic [PTR_W:0]    f_wr, f_rd;
   logic              f_empty, f_full;

   logic              accept, do_wr, do_rd, last_wr, push, ovf;

   assign f_empty = (f_wr == f_rd);
   assign f_full  = (f_wr[PTR_W] != f_rd[PTR_W]) && (f_wr[PTR_W-1:0] == f_rd[PTR_W-1:0]);
   assign accept  = (state == IDLE) && start;

   // NOTE: every always_comb output gets a default first so no path can infer a latch.
   always_comb begin
      state_nx = state;
      do_wr    = 1'b0;
      do_rd    = 1'b0;
      last_wr  = 1'b0;
      unique case (state)
         IDLE: if (start) state_nx = RUN;
         RUN: begin
            if (!f_empty) begin
               do_wr = 1'b1;
               if (wr_cnt == CNT_W'(BEATS - 1)) begin
                  last_wr  = 1'b1;
                  state_nx = IDLE;
               end
            end else if (rd_cnt < CNT_W'(BEATS)) begin
               do_rd = 1'b1;
            end
         end
         default: state_nx = IDLE;
      endcase
   end

   // Pop is honoured in the same cycle, so a full FIFO still accepts a beat while writing.
   assign push = ntt_valid_out && (!f_full || do_wr);
   assign ovf  = ntt_valid_out && f_full && !do_wr;

   assign busy            = (state == RUN);
   assign done            = done_q;
   assign err_overflow    = err_q;
   assign mem_wenb        = do_wr;
   assign mem_renb        = do_rd;
   assign mem_webb        = {4{do_wr}};
   assign mem_w_is_vector = do_wr;
   assign mem_addrb       = do_wr ? wr_ptr : (do_rd ? rd_ptr : '0);
   assign mem_datab       = do_wr ? fifo_mem[f_rd[PTR_W-1:0]] : '0;
   assign ntt_valid_in    = valid_in_q;
   assign ntt_lane_in     = valid_in_q ? mem_qb : '0;

   // NOTE: sequential state uses non-blocking assignments so all registers update together.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= IDLE;
         rd_ptr     <= '0;
         wr_ptr     <= '0;
         rd_cnt     <= '0;
         wr_cnt     <= '0;
         done_q     <= 1'b0;
         valid_in_q <= 1'b0;
         err_q      <= 1'b0;
         f_wr       <= '0;
         f_rd       <= '0;
      end else begin
         state      <= state_nx;
         done_q     <= last_wr;
         valid_in_q <= do_rd;
         if (accept) begin
            rd_ptr <= src_addr;
            wr_ptr <= dst_addr;
            rd_cnt <= '0;
            wr_cnt <= '0;
         end else if (do_wr) begin
            wr_ptr <= wr_ptr + ADDR_W'(LANE);
            wr_cnt <= wr_cnt + 1'b1;
         end else if (do_rd) begin
            rd_ptr <= rd_ptr + ADDR_W'(LANE);
            rd_cnt <= rd_cnt + 1'b1;
         end
         if (accept)   err_q <= ovf;
         else if (ovf) err_q <= 1'b1;
         if (push)  f_wr <= f_wr + 1'b1;
         if (do_wr) f_rd <= f_rd + 1'b1;
      end
   end

   // NOTE: the FIFO storage is not reset; the cleared pointers already mark it empty.
   always_ff @(posedge clk) begin
      if (push) fifo_mem[f_wr[PTR_W-1:0]] <= ntt_lane_out;
   end

endmodule

// File: doc/ntt_lane_dma.md
Name: ntt_lane_dma

Overview:
- Vector DMA sequencer between the shared dual-port data memory (port B) and the NTT core.
- On a start pulse it streams BEATS beats of LANE 32-bit coefficients from memory into the NTT lane input.
- It captures the NTT lane output beats in a small FIFO and writes them back to a destination region as vector writes.
- It replaces the simulation-only feeder and dump logic around the NTT with a synthesizable sequencer.

Parameters:
- LANE, 8, 32-bit words per beat; must equal the memory vector width.
- BEATS, 64, beats per polynomial (512 coefficients).
- ADDR_W, 14, word-address width of memory port B.
- FIFO_DEPTH, 4, output-beat buffer depth; power of 2, minimum 2.

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous reset, active-low
- start  in  1  one-cycle request; ignored while busy=1
- src_addr  in  ADDR_W  source word address; sampled when start is accepted
- dst_addr  in  ADDR_W  destination word address; sampled when start is accepted
- busy  out  1  transfer in progress
- done  out  1  one-cycle pulse after the last write-back is issued
- err_overflow  out  1  sticky; set when a beat arrives while the FIFO is full
- mem_renb  out  1  port B vector read enable
- mem_wenb  out  1  port B write enable
- mem_webb  out  4  byte enables; 4'hF whenever mem_wenb=1, else 0
- mem_w_is_vector  out  1  1 whenever mem_wenb=1
- mem_addrb  out  ADDR_W  port B word address
- mem_datab  out  LANE x 32  write data (FIFO head)
- mem_qb  in  LANE x 32  read data, valid the cycle after mem_renb
- ntt_valid_in  out  1  lane_in beat valid
- ntt_lane_in  out  LANE x 32  beat to NTT
- ntt_valid_out  in  1  NTT output beat valid
- ntt_lane_out  in  LANE x 32  NTT output beat

Behaviour:
- Reset (asynchronous, rst_n=0):
  - State IDLE; counters, pointers and FIFO cleared.
  - All outputs 0, including err_overflow.
  - Reset mid-transfer abandons the transfer; no done pulse.
- States:
  - IDLE -> RUN on start.
  - RUN -> IDLE when wr_cnt reaches BEATS.
  - done=1 for the single cycle after the final write is issued; busy returns to 0 in that same cycle.
- Start acceptance:
  - In IDLE, start loads rd_ptr=src_addr, wr_ptr=dst_addr and clears rd_cnt, wr_cnt; busy=1 the next cycle.
  - start while busy is ignored.
- Port B arbitration, one access per cycle in RUN:
  - Write has priority: if the FIFO is non-empty, assert mem_wenb with mem_addrb=wr_ptr and mem_datab=FIFO head, then pop the FIFO, wr_ptr+=LANE, wr_cnt++.
  - Otherwise, if rd_cnt<BEATS, assert mem_renb with mem_addrb=rd_ptr, then rd_ptr+=LANE, rd_cnt++.
  - mem_renb and mem_wenb are never both 1.
- Read path latency:
  - ntt_valid_in is mem_renb delayed by one register stage.
  - ntt_lane_in = mem_qb, combinational in the cycle ntt_valid_in=1; it is 0 when ntt_valid_in=0.
  - Beats reach the NTT in source-address order. Gaps are allowed when a write preempts a read.
- Output capture:
  - ntt_valid_out=1 pushes ntt_lane_out into the FIFO in every state, including IDLE (late beats after reset are still buffered).
  - Push and pop in the same cycle is legal, including when the FIFO is full.
  - A push with the FIFO full and no pop drops the beat and sets err_overflow. err_overflow clears only on reset or on an accepted start.
- Address arithmetic:
  - ADDR_W bits, modulo 2^ADDR_W (wraps silently).
  - Overlapping src/dst regions are permitted. A read issued after a write to the same address returns the new data.
- Completion:
  - Completion counts writes only: wr_cnt==BEATS.
  - If the NTT produces fewer than BEATS beats, the block stays busy indefinitely; recovery is by reset.

Test Plan:
- Basic transfer:
  - Stimulus: memory[0x000..0x1FF]=index value, src=0x000, dst=0x200, NTT modelled as a 3-cycle delay of lane_in.
  - Required: 64 reads at addresses 0x000, 0x008, ... 0x1F8; memory[0x200+i]=i for all 512 i; exactly one done pulse; err_overflow=0.
- Write priority:
  - Stimulus: NTT model with 1-cycle latency.
  - Required: reads and writes alternate with mem_renb and mem_wenb never both 1; FIFO occupancy never exceeds 2; transfer completes in at most 2*64+4 cycles after start.
- Overflow:
  - Stimulus: hold ntt_valid_out=1 for 6 cycles while in IDLE (no pops).
  - Required: FIFO holds the first 4 beats; err_overflow=1 from the 5th beat onward and stays set until the next start.
- start while busy:
  - Stimulus: start pulsed at cycle 10 of a transfer with src=0x400.
  - Required: ignored; all reads stay in the original src range; exactly one done pulse.
- Reset mid-operation:
  - Stimulus: rst_n=0 after 20 beats, then a new start with src=0x800, dst=0xC00.
  - Required: all outputs 0 during reset; the new transfer completes from 0x800 and writes to 0xC00..0xDFF.
- Address wrap:
  - Stimulus: src=0x3FF8, ADDR_W=14.
  - Required: the second read is at 0x0000.
